// File: rtl/gpio_irq_pkg.sv
// Shared register map and CTRL bit positions for the Wishbone GPIO/IRQ peripheral.
package gpio_irq_pkg;

  localparam logic [3:0] REG_OE      = 4'd0;
  localparam logic [3:0] REG_OUT     = 4'd1;
  localparam logic [3:0] REG_IN      = 4'd2;
  localparam logic [3:0] REG_OUT_SET = 4'd3;
  localparam logic [3:0] REG_OUT_CLR = 4'd4;
  localparam logic [3:0] REG_RISE_EN = 4'd5;
  localparam logic [3:0] REG_FALL_EN = 4'd6;
  localparam logic [3:0] REG_STATUS  = 4'd7;
  localparam logic [3:0] REG_CNT     = 4'd8;
  localparam logic [3:0] REG_CMP     = 4'd9;
  localparam logic [3:0] REG_CTRL    = 4'd10;

  localparam int CTRL_EDGE_IE  = 0;
  localparam int CTRL_CMP_IE   = 1;
  localparam int CTRL_CMP_FLAG = 2;

endpackage

// File: rtl/gpio_edge_det.sv
// Per-pin rising/falling edge detector with sticky write-1-to-clear status.
module gpio_edge_det #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_in,
  input  logic [N-1:0] i_rise_en,
  input  logic [N-1:0] i_fall_en,
  input  logic [N-1:0] i_w1c,
  output logic [N-1:0] o_status
);

  logic [N-1:0] r_in_d;
  logic [N-1:0] r_status;
  logic [N-1:0] w_rise;
  logic [N-1:0] w_fall;

  assign w_rise   = i_in & ~r_in_d & i_rise_en;
  assign w_fall   = ~i_in & r_in_d & i_fall_en;
  assign o_status = r_status;

  // A new event in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_d   <= '0;
      r_status <= '0;
    end else begin
      r_in_d   <= i_in;
      r_status <= (r_status & ~i_w1c) | w_rise | w_fall;
    end
  end

endmodule

// File: rtl/gpio_irq_wb.sv
// Wishbone GPIO peripheral: atomic set/clear outputs, edge status, cycle counter
// with compare match, and a registered level interrupt.
module gpio_irq_wb
  import gpio_irq_pkg::*;
#(
  parameter int N     = 16,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  inout  wire  [N-1:0] gpio_pads,
  output logic [N-1:0] gpio_in,
  output logic         irq,
  input  logic [31:0]  wb_wdata,
  output logic [31:0]  wb_rdata,
  input  logic [3:0]   wb_addr,
  input  logic         wb_we,
  input  logic         wb_cyc,
  output logic         wb_ack
);

  logic             r_ack;
  logic [31:0]      r_rdata;
  logic             r_wr_stb;
  logic [3:0]       r_wr_addr;
  logic [31:0]      r_wr_data;
  logic [N-1:0]     r_oe;
  logic [N-1:0]     r_out;
  logic [N-1:0]     r_rise_en;
  logic [N-1:0]     r_fall_en;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_cmp;
  logic             r_cnt_run;
  logic             r_cmp_flag;
  logic             r_edge_ie;
  logic             r_cmp_ie;
  logic             r_irq;
  logic [N-1:0]     r_pad_oe;
  logic [N-1:0]     r_pad_out;
  logic [N-1:0]     r_pad_in;

  logic [N-1:0]     w_status;
  logic [N-1:0]     w_status_w1c;
  logic [31:0]      w_rd;
  logic             w_req;
  logic             w_cnt_load;
  logic             w_flag_clr;
  logic             w_match;

  assign w_req        = wb_cyc & ~r_ack;
  assign w_status_w1c = (r_wr_stb && r_wr_addr == REG_STATUS) ? r_wr_data[N-1:0] : '0;
  assign w_cnt_load   = r_wr_stb && r_wr_addr == REG_CNT;
  assign w_flag_clr   = r_wr_stb && r_wr_addr == REG_CTRL && r_wr_data[CTRL_CMP_FLAG];
  // Values placed by reset or a load are not matches; only counted values are.
  assign w_match      = (r_cnt == r_cmp) & r_cnt_run & ~w_cnt_load;

  assign wb_ack   = r_ack;
  assign wb_rdata = r_rdata;
  assign irq      = r_irq;
  assign gpio_in  = r_pad_in;

  always_comb begin
    w_rd = '0;
    case (wb_addr)
      REG_OE:      w_rd[N-1:0]     = r_oe;
      REG_OUT:     w_rd[N-1:0]     = r_out;
      REG_IN:      w_rd[N-1:0]     = r_pad_in;
      REG_RISE_EN: w_rd[N-1:0]     = r_rise_en;
      REG_FALL_EN: w_rd[N-1:0]     = r_fall_en;
      REG_STATUS:  w_rd[N-1:0]     = w_status;
      REG_CNT:     w_rd[CNT_W-1:0] = r_cnt;
      REG_CMP:     w_rd[CNT_W-1:0] = r_cmp;
      REG_CTRL:    w_rd[2:0]       = {r_cmp_flag, r_cmp_ie, r_edge_ie};
      default:     ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_ack     <= w_req;
      r_wr_stb  <= w_req & wb_we;
      r_wr_addr <= wb_addr;
      r_wr_data <= wb_wdata;
      r_rdata   <= (w_req & ~wb_we) ? w_rd : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oe      <= '0;
      r_out     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_cmp     <= '0;
      r_edge_ie <= 1'b0;
      r_cmp_ie  <= 1'b0;
    end else if (r_wr_stb) begin
      case (r_wr_addr)
        REG_OE:      r_oe      <= r_wr_data[N-1:0];
        REG_OUT:     r_out     <= r_wr_data[N-1:0];
        REG_OUT_SET: r_out     <= r_out | r_wr_data[N-1:0];
        REG_OUT_CLR: r_out     <= r_out & ~r_wr_data[N-1:0];
        REG_RISE_EN: r_rise_en <= r_wr_data[N-1:0];
        REG_FALL_EN: r_fall_en <= r_wr_data[N-1:0];
        REG_CMP:     r_cmp     <= r_wr_data[CNT_W-1:0];
        REG_CTRL: begin
          r_edge_ie <= r_wr_data[CTRL_EDGE_IE];
          r_cmp_ie  <= r_wr_data[CTRL_CMP_IE];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cnt_run  <= 1'b0;
      r_cmp_flag <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_load ? r_wr_data[CNT_W-1:0] : r_cnt + CNT_W'(1);
      r_cnt_run  <= ~w_cnt_load;
      r_cmp_flag <= (r_cmp_flag & ~w_flag_clr) | w_match;
      r_irq      <= (r_edge_ie & |w_status) | (r_cmp_ie & r_cmp_flag);
    end
  end

  gpio_edge_det #(.N(N)) u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_in      (r_pad_in),
    .i_rise_en (r_rise_en),
    .i_fall_en (r_fall_en),
    .i_w1c     (w_status_w1c),
    .o_status  (w_status)
  );

  // IOB-equivalent pad cells: registered in/out/OE; pull-up lives in the pad.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pad_oe  <= '0;
      r_pad_out <= '0;
      r_pad_in  <= '0;
    end else begin
      r_pad_oe  <= r_oe;
      r_pad_out <= r_out;
      r_pad_in  <= gpio_pads;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pad
    assign gpio_pads[g] = r_pad_oe[g] ? r_pad_out[g] : 1'bz;
  end

endmodule

// File: tb/tb_gpio_irq_wb.sv
// Directed bench for gpio_irq_wb: a 16-pin/32-bit instance plus a 5-pin/8-bit instance.
module tb_gpio_irq_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_addr;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_cyc5;
  wire  [15:0] pads;
  wire  [4:0]  pads5;
  logic [15:0] gpio_in;
  logic        irq;
  logic [31:0] rdata;
  logic        ack;
  logic [4:0]  gpio_in5;
  logic        irq5;
  logic [31:0] rdata5;
  logic        ack5;
  logic [15:0] drv_en;
  logic [15:0] drv_val;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup pu (pads[i]);
    assign pads[i] = drv_en[i] ? drv_val[i] : 1'bz;
  end
  for (genvar i = 0; i < 5; i++) begin : g_pu5
    pullup pu (pads5[i]);
  end

  gpio_irq_wb #(.N(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .gpio_pads(pads), .gpio_in(gpio_in), .irq(irq),
    .wb_wdata(wb_wdata), .wb_rdata(rdata), .wb_addr(wb_addr), .wb_we(wb_we),
    .wb_cyc(wb_cyc), .wb_ack(ack)
  );

  gpio_irq_wb #(.N(5), .CNT_W(8)) dut5 (
    .clk(clk), .rst_n(rst_n), .gpio_pads(pads5), .gpio_in(gpio_in5), .irq(irq5),
    .wb_wdata(wb_wdata), .wb_rdata(rdata5), .wb_addr(wb_addr), .wb_we(wb_we),
    .wb_cyc(wb_cyc5), .wb_ack(ack5)
  );

  // Bus drivers; called at a negedge, return at the negedge after the ack cycle.
  task automatic bus_rd(input bit sel5, input logic [3:0] a, output logic [31:0] d,
                        output logic [1:0] ackseq);
    wb_addr = a; wb_we = 1'b0; wb_wdata = '0;
    if (sel5) wb_cyc5 = 1'b1; else wb_cyc = 1'b1;
    @(negedge clk);
    d = sel5 ? rdata5 : rdata;
    ackseq[1] = sel5 ? ack5 : ack;
    wb_cyc = 1'b0; wb_cyc5 = 1'b0;
    @(negedge clk);
    ackseq[0] = sel5 ? ack5 : ack;
  endtask

  task automatic bus_wr(input bit sel5, input logic [3:0] a, input logic [31:0] v,
                        output logic [1:0] ackseq);
    wb_addr = a; wb_we = 1'b1; wb_wdata = v;
    if (sel5) wb_cyc5 = 1'b1; else wb_cyc = 1'b1;
    @(negedge clk);
    ackseq[1] = sel5 ? ack5 : ack;
    wb_cyc = 1'b0; wb_cyc5 = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    ackseq[0] = sel5 ? ack5 : ack;
  endtask

  task automatic test_reset();
    logic [31:0] d, exp;
    logic [1:0]  as;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (ack !== 1'b0 || irq !== 1'b0 || rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_outs: ack=%b irq=%b rdata=%h want 0 0 0", ack, irq, rdata); end
    n_cmp++; if (pads !== 16'hFFFF || gpio_in !== 16'h0) begin
      n_err++; $display("FAIL reset_pads: pads=%h gpio_in=%h want ffff 0000", pads, gpio_in); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int a = 0; a < 16; a++) begin
      bus_rd(1'b0, 4'(a), d, as);
      n_cmp++; if (as !== 2'b10) begin
        n_err++; $display("FAIL reset_ack_a%0d: got %b want 10", a, as); end
      if (a == 8) begin
        n_cmp++; if (d === 32'h0) begin
          n_err++; $display("FAIL reset_cnt_running: got %h want nonzero", d); end
      end else begin
        exp = (a == 2) ? 32'h0000_FFFF : 32'h0;
        n_cmp++; if (d !== exp) begin
          n_err++; $display("FAIL reset_rd_a%0d: got %h want %h", a, d, exp); end
      end
    end
  endtask

  task automatic test_out();
    logic [31:0] d;
    logic [1:0]  as;
    bus_wr(1'b0, 4'd1, 32'h0000_00F0, as);
    bus_wr(1'b0, 4'd3, 32'h0000_0003, as);
    bus_wr(1'b0, 4'd4, 32'h0000_0010, as);
    n_cmp++; if (as !== 2'b10) begin n_err++; $display("FAIL wr_ack: got %b want 10", as); end
    bus_rd(1'b0, 4'd1, d, as);
    n_cmp++; if (d !== 32'h0000_00E3) begin n_err++; $display("FAIL out_rd: got %h want 000000e3", d); end
    bus_rd(1'b0, 4'd3, d, as);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL out_set_rd: got %h want 0", d); end
    bus_wr(1'b0, 4'd0, 32'h0000_FFFF, as);
    n_cmp++; if (pads !== 16'hFFFF) begin n_err++; $display("FAIL pad_pre: got %h want ffff", pads); end
    @(negedge clk);
    n_cmp++; if (pads !== 16'h00E3 || gpio_in !== 16'hFFFF) begin
      n_err++; $display("FAIL pad_drive: pads=%h gpio_in=%h want 00e3 ffff", pads, gpio_in); end
    @(negedge clk);
    n_cmp++; if (gpio_in !== 16'h00E3) begin n_err++; $display("FAIL gpio_in_echo: got %h want 00e3", gpio_in); end
    bus_rd(1'b0, 4'd2, d, as);
    n_cmp++; if (d !== 32'h0000_00E3) begin n_err++; $display("FAIL in_rd: got %h want 000000e3", d); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] as;
    logic       exp_ack;
    wb_addr = 4'd1; wb_we = 1'b0; wb_cyc = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_ack = (k % 2 == 0);
      n_cmp++; if (ack !== exp_ack || rdata !== (exp_ack ? 32'h0000_00E3 : 32'h0)) begin
        n_err++; $display("FAIL b2b_k%0d: ack=%b rdata=%h want %b %h", k, ack, rdata, exp_ack,
                          exp_ack ? 32'h0000_00E3 : 32'h0); end
    end
    wb_cyc = 1'b0;
    @(negedge clk);
    bus_wr(1'b0, 4'd0, 32'h0, as);
  endtask

  task automatic test_edge();
    logic [31:0] d;
    logic [1:0]  as;
    drv_val[0] = 1'b0; drv_en[0] = 1'b1;
    repeat (3) @(negedge clk);
    bus_wr(1'b0, 4'd5, 32'h1, as);
    bus_wr(1'b0, 4'd10, 32'h1, as);
    drv_val[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_edge: got %b want 1", irq); end
    bus_rd(1'b0, 4'd7, d, as);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL status_rise: got %h want 1", d); end
    bus_wr(1'b0, 4'd7, 32'h1, as);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_hold: got %b want 1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    drv_val[0] = 1'b0;
    repeat (3) @(negedge clk);
    wb_addr = 4'd7; wb_we = 1'b1; wb_wdata = 32'h1; wb_cyc = 1'b1; drv_val[0] = 1'b1;
    @(negedge clk);
    wb_cyc = 1'b0; wb_we = 1'b0;
    @(negedge clk);
    bus_rd(1'b0, 4'd7, d, as);
    n_cmp++; if (d !== 32'h1) begin n_err++; $display("FAIL status_set_wins: got %h want 1", d); end
    bus_wr(1'b0, 4'd6, 32'h2, as);
    drv_val[1] = 1'b0; drv_en[1] = 1'b1;
    repeat (3) @(negedge clk);
    bus_rd(1'b0, 4'd7, d, as);
    n_cmp++; if (d !== 32'h3) begin n_err++; $display("FAIL status_fall: got %h want 3", d); end
    bus_wr(1'b0, 4'd5, 32'h0, as);
    bus_wr(1'b0, 4'd6, 32'h0, as);
    bus_wr(1'b0, 4'd10, 32'h0, as);
    drv_en = '0;
    repeat (3) @(negedge clk);
    bus_wr(1'b0, 4'd7, 32'h3, as);
    bus_rd(1'b0, 4'd7, d, as);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL status_w1c: got %h want 0", d); end
  endtask

  task automatic test_cnt();
    logic [31:0] d;
    logic [1:0]  as;
    bus_wr(1'b0, 4'd9, 32'h1, as);
    bus_wr(1'b0, 4'd10, 32'h2, as);
    bus_wr(1'b0, 4'd8, 32'hFFFF_FFFE, as);
    bus_rd(1'b0, 4'd8, d, as);
    n_cmp++; if (d !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL cnt_load: got %h want fffffffe", d); end
    bus_rd(1'b0, 4'd8, d, as);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL cnt_wrap: got %h want 0", d); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL cmp_irq_early: got %b want 0", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL cmp_irq: got %b want 1", irq); end
    bus_rd(1'b0, 4'd10, d, as);
    n_cmp++; if (d !== 32'h6) begin n_err++; $display("FAIL ctrl_flag: got %h want 6", d); end
    bus_wr(1'b0, 4'd10, 32'h6, as);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL cmp_irq_hold: got %b want 1", irq); end
    @(negedge clk);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL cmp_irq_clear: got %b want 0", irq); end
    bus_rd(1'b0, 4'd10, d, as);
    n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL ctrl_w1c: got %h want 2", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0]  as;
    bus_wr(1'b0, 4'd0, 32'h0000_00FF, as);
    @(negedge clk);
    n_cmp++; if (pads !== 16'hFFE3) begin n_err++; $display("FAIL mid_pads_pre: got %h want ffe3", pads); end
    wb_addr = 4'd1; wb_we = 1'b1; wb_wdata = 32'h55; wb_cyc = 1'b1;
    @(negedge clk);
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL mid_ack_pre: got %b want 1", ack); end
    rst_n = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    #1;
    n_cmp++; if (ack !== 1'b0 || pads !== 16'hFFFF) begin
      n_err++; $display("FAIL mid_reset: ack=%b pads=%h want 0 ffff", ack, pads); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus_rd(1'b0, 4'd1, d, as);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_out: got %h want 0", d); end
    bus_rd(1'b0, 4'd0, d, as);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL mid_oe: got %h want 0", d); end
  endtask

  task automatic test_n5();
    logic [31:0] d;
    logic [1:0]  as;
    bus_wr(1'b1, 4'd6, 32'hFFFF_FFFF, as);
    bus_wr(1'b1, 4'd0, 32'hFFFF_FFFF, as);
    repeat (3) @(negedge clk);
    bus_rd(1'b1, 4'd0, d, as);
    n_cmp++; if (d !== 32'h1F) begin n_err++; $display("FAIL n5_oe: got %h want 1f", d); end
    bus_rd(1'b1, 4'd6, d, as);
    n_cmp++; if (d !== 32'h1F) begin n_err++; $display("FAIL n5_fall_en: got %h want 1f", d); end
    bus_rd(1'b1, 4'd7, d, as);
    n_cmp++; if (d !== 32'h1F) begin n_err++; $display("FAIL n5_status: got %h want 1f", d); end
    bus_rd(1'b1, 4'd2, d, as);
    n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL n5_in: got %h want 0", d); end
    bus_rd(1'b1, 4'd12, d, as);
    n_cmp++; if (d !== 32'h0 || as !== 2'b10) begin
      n_err++; $display("FAIL n5_a12: got %h/%b want 0/10", d, as); end
    bus_wr(1'b1, 4'd1, 32'hFFFF_FFFF, as);
    bus_rd(1'b1, 4'd1, d, as);
    n_cmp++; if (d !== 32'h1F) begin n_err++; $display("FAIL n5_out: got %h want 1f", d); end
  endtask

  initial begin
    rst_n = 1'b0; wb_cyc = 1'b0; wb_cyc5 = 1'b0; wb_we = 1'b0;
    wb_addr = '0; wb_wdata = '0; drv_en = '0; drv_val = '0;
    test_reset();
    test_out();
    test_back_to_back();
    test_edge();
    test_cnt();
    test_reset_mid();
    test_n5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
